pipe_stage_ctrl: RTL and testbench
==================================

# pipe_stage_ctrl

- Controlled pipeline stage for the 20-bit inter-stage buses of the processor datapath.
- Wraps a WIDTH-bit pipeline register with:
  - a valid/ready handshake;
  - a one-entry skid buffer, so backpressure never drops a word;
  - a synchronous flush for branch/exception squash;
  - a programmable hold counter that stalls the output for multi-cycle operations.
- Sits between two pipeline stages in place of a bare clocked register.

## Interface
- WIDTH, 20, data bus width in bits
- HOLD_W, 4, width of the hold-cycle count
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  WIDTH  upstream word
- out_valid  out  1  stage presents a word downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  word presented downstream
- flush  in  1  discard all held words (synchronous)
- hold_req  in  1  request an output hold
- hold_cycles  in  HOLD_W  hold length in cycles
- count  out  2  words held (0–2)
- hold_active  out  1  hold counter nonzero

## Operation
- States:
  - EMPTY: no word held.
  - BUSY: main register valid.
  - FULL: main and skid registers both valid.
- Definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (state != FULL). Decoded from the state register only; no combinational path from out_ready.
- out_valid = (state != EMPTY) & (hold_cnt == 0).
- out_data = main register.
- Transitions:
  - EMPTY, push: → BUSY, main ← in_data.
  - BUSY, push & pop: stay BUSY, main ← in_data.
  - BUSY, push only: → FULL, skid ← in_data.
  - BUSY, pop only: → EMPTY.
  - FULL, pop: → BUSY, main ← skid. No push is possible in FULL.
  - Otherwise: hold state and data.
- Flush:
  - Highest priority: next state EMPTY and hold_cnt ← 0.
  - A push or pop in the same cycle is discarded and has no effect.
  - The upstream handshake still completes, because in_ready was high. The word is intentionally dropped.
- Hold counter:
  - Loads only when hold_req = 1, hold_cnt = 0 and flush = 0: hold_cnt ← hold_cycles.
  - Decrements by 1 each cycle while nonzero.
  - hold_req while hold_cnt ≠ 0 is ignored, not queued.
  - hold_cycles = 0 has no effect.
- While hold is active, pushes continue up to FULL; pops are blocked because out_valid = 0.
- count: EMPTY = 0, BUSY = 1, FULL = 2.
- hold_active = (hold_cnt != 0).
- Data registers are not cleared on flush; out_data content is don't-care while out_valid = 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state EMPTY, hold_cnt 0.
  - out_valid 0, out_data 0, in_ready 1, count 0, hold_active 0.
  - Skid register 0.
- Latency:
  - A word pushed in cycle t is presented with out_valid = 1 in cycle t+1, provided no hold is active.
  - Throughput is 1 word/cycle with out_ready held high.
- Hold timing: a hold loaded in cycle t forces out_valid = 0 in cycles t+1 … t+N. out_valid can return in cycle t+N+1.
- Backpressure:
  - out_ready low for one cycle while BUSY with in_valid high → FULL. in_ready drops in the next cycle.
  - No word is lost or duplicated.
- Ordering: strict FIFO order. The main register always holds the older word.
- Reset mid-operation: all words and the hold are lost immediately; outputs take their reset values asynchronously.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (EMPTY/BUSY/FULL, 2-bit encoding);
  - DATA_W = 20;
  - the default HOLD_W.
- One sub-module, `pipe_data_reg`: WIDTH-bit register with async active-low reset and load enable.
  - Instantiated twice, for the main and skid registers.
  - The FSM and hold counter live in the top module.

## Test plan
- Reset then idle → in_ready = 1, out_valid = 0, count = 0.
- Streaming: push 0x00001, 0x00002, 0x00003 on consecutive cycles with out_ready = 1 → same values out on cycles t+1, t+2, t+3, in order, count = 1 throughout.
- Backpressure:
  - Push 0xABCDE, then 0x12345, with out_ready = 0 → count = 2, in_ready = 0.
  - Raise out_ready → 0xABCDE, then 0x12345, no loss.
- Hold:
  - hold_req with hold_cycles = 3 while BUSY → out_valid = 0 for exactly 3 cycles, hold_active = 1, then the word is presented.
  - A second hold_req mid-hold is ignored.
- Flush:
  - In FULL with a simultaneous pop → next cycle EMPTY, count = 0, out_valid = 0.
  - The next pushed word, 0x0F0F0, appears one cycle later.
- Reset asserted while FULL with a hold active → all outputs take their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the controlled pipeline stage.
package pipe_ctrl_pkg;

    localparam int DATA_W         = 20;
    localparam int HOLD_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake, data and control bundle between a pipeline stage and its neighbours.
interface pipe_stage_ctrl_if #(
    parameter int WIDTH  = 20,
    parameter int HOLD_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              flush;
    logic              hold_req;
    logic [HOLD_W-1:0] hold_cycles;
    logic [1:0]        count;
    logic              hold_active;

    // Side that drives words and control into the stage
    modport master (
        output in_valid, in_data, out_ready, flush, hold_req, hold_cycles,
        input  in_ready, out_valid, out_data, count, hold_active
    );

    // The stage itself
    modport slave (
        input  in_valid, in_data, out_ready, flush, hold_req, hold_cycles,
        output in_ready, out_valid, out_data, count, hold_active
    );
endinterface

// File: rtl/pipe_data_reg.sv
// Plain WIDTH-bit data register with load enable, cleared by reset.
module pipe_data_reg #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // Capture the input word when load is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a programmable output hold.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | no word held
//   ST_BUSY  | main register holds one word
//   ST_FULL  | main holds the older word, skid the newer
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int HOLD_W = HOLD_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stage_ctrl_if.slave     bus
);
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic              w_hold_zero;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_main_load;
    logic              w_skid_load;
    logic [WIDTH-1:0]  w_main_d;
    logic [WIDTH-1:0]  w_main_q;
    logic [WIDTH-1:0]  w_skid_q;

    // Handshake qualifiers decoded from registers only, so in_ready has no
    // path from out_ready.
    assign w_hold_zero = (r_hold_cnt == '0);
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY) && w_hold_zero;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Main takes the skid word when draining from FULL, otherwise the input.
    // Flush suppresses every load; the data left behind is don't-care.
    assign w_main_load = !bus.flush &&
                         (((r_state == ST_EMPTY) && w_push) ||
                          ((r_state == ST_BUSY)  && w_push && w_pop) ||
                          ((r_state == ST_FULL)  && w_pop));
    assign w_skid_load = !bus.flush && (r_state == ST_BUSY) && w_push && !w_pop;
    assign w_main_d    = (r_state == ST_FULL) ? w_skid_q : bus.in_data;

    pipe_data_reg #(.WIDTH(WIDTH)) u_main_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skid_load),
        .i_d    (bus.in_data),
        .o_q    (w_skid_q)
    );

    // Occupancy FSM; flush overrides any handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (bus.flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_BUSY;
                ST_BUSY: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (!w_push && w_pop) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_pop) r_state <= ST_BUSY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Hold down-counter; a request while counting is dropped, not queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (bus.flush) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_zero) begin
            r_hold_cnt <= r_hold_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
        end else if (bus.hold_req) begin
            r_hold_cnt <= bus.hold_cycles;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_main_q;
    assign bus.hold_active = !w_hold_zero;
    assign bus.count       = (r_state == ST_FULL) ? 2'd2 :
                             (r_state == ST_BUSY) ? 2'd1 : 2'd0;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl with a word scoreboard and a
// reference occupancy/hold model checked every cycle.
module tb_pipe_stage_ctrl;
    localparam int W  = 20;
    localparam int HW = 4;

    logic clk;
    logic rst_n;

    pipe_stage_ctrl_if #(.WIDTH(W), .HOLD_W(HW)) bus ();

    pipe_stage_ctrl #(.WIDTH(W), .HOLD_W(HW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q[$];
    int m_hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge check outputs against the model and
    // account the handshake, then return just after the rising edge.
    task automatic step();
        logic exp_ov, exp_ir, push, pop;
        @(negedge clk);
        exp_ov = (q.size() != 0) && (m_hold == 0);
        exp_ir = (q.size() != 2);
        chk("count",       32'(bus.count),       32'(q.size()));
        chk("in_ready",    32'(bus.in_ready),    32'(exp_ir));
        chk("out_valid",   32'(bus.out_valid),   32'(exp_ov));
        chk("hold_active", 32'(bus.hold_active), 32'(m_hold != 0));
        push = bus.in_valid && exp_ir;
        pop  = exp_ov && bus.out_ready;
        if (pop) chk("out_data", 32'(bus.out_data), 32'(q[0]));
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(bus.in_data);
        end
        if (bus.flush)                            m_hold = 0;
        else if (m_hold != 0)                     m_hold = m_hold - 1;
        else if (bus.hold_req)                    m_hold = int'(bus.hold_cycles);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lowcnt;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus.flush       = 1'b0;
        bus.hold_req    = 1'b0;
        bus.hold_cycles = '0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset / idle
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        step();

        // Streaming at full throughput
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 20'h00001; step();
        chk("stream_lat1", 32'(bus.out_data), 32'h00001);
        bus.in_data = 20'h00002; step();
        chk("stream_cnt2", 32'(bus.count), 32'd1);
        chk("stream_lat2", 32'(bus.out_data), 32'h00002);
        bus.in_data = 20'h00003; step();
        chk("stream_cnt3", 32'(bus.count), 32'd1);
        chk("stream_lat3", 32'(bus.out_data), 32'h00003);
        bus.in_valid = 1'b0; step();
        chk("stream_empty", 32'(bus.count), 32'd0);

        // Backpressure into the skid register
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'hABCDE; step();
        bus.in_data = 20'h12345; step();
        bus.in_valid = 1'b0;
        chk("bp_count",    32'(bus.count),    32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head",     32'(bus.out_data), 32'hABCDE);
        bus.out_ready = 1'b1; step();
        chk("bp_second",   32'(bus.out_data), 32'h12345);
        step();
        chk("bp_drained",  32'(bus.count),    32'd0);

        // Hold of 3 cycles, second request mid-hold ignored
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'h55555; step();
        bus.in_valid = 1'b0;
        bus.hold_req = 1'b1; bus.hold_cycles = 4'd3; step();
        chk("hold_active_on", 32'(bus.hold_active), 32'd1);
        bus.hold_cycles = 4'd7;
        bus.out_ready = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) break;
            lowcnt++;
            step();
            bus.hold_req = 1'b0;
        end
        bus.hold_req = 1'b0;
        chk("hold_low_cycles", 32'(lowcnt), 32'd3);
        chk("hold_word", 32'(bus.out_data), 32'h55555);
        step();
        chk("hold_done_cnt", 32'(bus.count), 32'd0);
        chk("hold_done_act", 32'(bus.hold_active), 32'd0);

        // Flush in FULL together with a pop, then a fresh word
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'h0AAAA; step();
        bus.in_data = 20'h0BBBB; step();
        bus.in_valid = 1'b0;
        chk("fl_full", 32'(bus.count), 32'd2);
        bus.out_ready = 1'b1; bus.flush = 1'b1; step();
        bus.flush = 1'b0;
        chk("fl_count",     32'(bus.count),     32'd0);
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 20'h0F0F0; step();
        bus.in_valid = 1'b0;
        chk("fl_next_valid", 32'(bus.out_valid), 32'd1);
        chk("fl_next_data",  32'(bus.out_data),  32'h0F0F0);
        step();

        // Asynchronous reset while FULL with a hold running
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'h11111; step();
        bus.in_data = 20'h22222; step();
        bus.in_valid = 1'b0;
        bus.hold_req = 1'b1; bus.hold_cycles = 4'd5; step();
        bus.hold_req = 1'b0;
        chk("ar_pre_count", 32'(bus.count),       32'd2);
        chk("ar_pre_hold",  32'(bus.hold_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid),   32'd0);
        chk("ar_out_data",  32'(bus.out_data),    32'd0);
        chk("ar_in_ready",  32'(bus.in_ready),    32'd1);
        chk("ar_count",     32'(bus.count),       32'd0);
        chk("ar_hold",      32'(bus.hold_active), 32'd0);
        q.delete();
        m_hold = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
